// File: rtl/oc_7_serial_gen.sv
// Serial generator: emits a 7-bit thermometer word holding n ones, one bit per cycle.
// Optional parity output enabled by defining OC_7_SERIAL_GEN_PARITY_EN.
module oc_7_serial_gen #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ww2,
  input  logic       ww1,
  input  logic       ww0,
  input  logic       start,
  output logic       ready,
  output logic [6:0] word,
  output logic       sout,
  output logic       sval,
  output logic [2:0] ocnt,
  output logic       done
`ifdef OC_7_SERIAL_GEN_PARITY_EN
  ,
  output logic       par
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic [6:0] therm7(input logic [2:0] n);
    logic [7:0] t;
    t = (8'd1 << n) - 8'd1;
    return t[6:0];
  endfunction

  function automatic logic [6:0] rev7(input logic [6:0] w);
    logic [6:0] r;
    for (int k = 0; k < 7; k++) begin
      r[k] = w[6 - k];
    end
    return r;
  endfunction

  function automatic logic parity7(input logic [6:0] w);
    return ^w;
  endfunction

  logic [1:0] state_r;
  logic [2:0] idx_r;
  logic [6:0] word_r;
  logic [6:0] sh_r;
  logic [2:0] ocnt_r;
  logic       ready_r;
  logic       sout_r;
  logic       sval_r;
  logic       done_r;

  logic [6:0] load_word_s;
  logic [6:0] load_sh_s;
  logic       load_s;

  // Pattern for a new request; the shift copy is pre-ordered so bit 0 leaves first
  always_comb begin
    load_word_s = therm7({ww2, ww1, ww0});
    if (MSB_FIRST != 0) begin
      load_sh_s = rev7(load_word_s);
    end else begin
      load_sh_s = load_word_s;
    end
    load_s = (state_r == IDLE) && start;
  end

  // Request FSM, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      word_r  <= 7'd0;
      sh_r    <= 7'd0;
      ocnt_r  <= 3'd0;
      ready_r <= 1'b1;
      sout_r  <= 1'b0;
      sval_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= SHIFT;
            idx_r   <= 3'd0;
            word_r  <= load_word_s;
            sh_r    <= {1'b0, load_sh_s[6:1]};
            sout_r  <= load_sh_s[0];
            ocnt_r  <= 3'd0;
            ready_r <= 1'b0;
            sval_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          // Never exceeds 7, since at most seven ones are emitted
          ocnt_r <= ocnt_r + {2'b00, sout_r};
          if (idx_r == 3'd6) begin
            state_r <= DONE;
            sval_r  <= 1'b0;
            sout_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            idx_r  <= idx_r + 3'd1;
            sout_r <= sh_r[0];
            sh_r   <= {1'b0, sh_r[6:1]};
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          sout_r  <= 1'b0;
          sval_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef OC_7_SERIAL_GEN_PARITY_EN
  logic par_r;

  // Parity of the word, captured together with the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_r <= 1'b0;
    end else if (load_s) begin
      par_r <= parity7(load_word_s);
    end else begin
      par_r <= par_r;
    end
  end

  assign par = par_r;
`endif

  assign ready = ready_r;
  assign word  = word_r;
  assign sout  = sout_r;
  assign sval  = sval_r;
  assign ocnt  = ocnt_r;
  assign done  = done_r;

endmodule

// File: doc/oc_7_serial_gen.md
OC_7_SERIAL_GEN -- requirements
Module: oc_7_serial_gen

Interface
REQ-001 Parameter MSB_FIRST, default 0, shift order: 0 = word bit 0 first, 1 = word bit 6 first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ww2, ww1, ww0  input  1 each  requested ones count n = {ww2,ww1,ww0}, range 0..7.
REQ-005 start  input  1  request strobe; sampled only while ready=1.
REQ-006 ready  output  1  high only in IDLE state.
REQ-007 word  output  7  latched thermometer pattern of current request.
REQ-008 sout  output  1  serial data bit; valid while sval=1.
REQ-009 sval  output  1  high during each of the 7 shift cycles.
REQ-010 ocnt  output  3  running count of ones emitted on sout in the current request.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 The block SHALL be the generator counterpart of the 7-input ones counter: for count n it emits a 7-bit word containing exactly n ones.
REQ-013 States: IDLE, SHIFT, DONE; no other reachable state.
REQ-014 IDLE: ready=1, sval=0, done=0; start=1 at an edge SHALL latch n, load word[k]=1 for k<n else 0, clear ocnt and bit index, and go to SHIFT.
REQ-015 SHIFT: sval=1 for exactly 7 consecutive cycles; sout = word[idx] with idx = 0..6 (MSB_FIRST=0) or 6..0 (MSB_FIRST=1).
REQ-016 ocnt SHALL increment at each SHIFT edge where sout=1; 3-bit width never wraps (max 7).
REQ-017 After the 7th shift cycle: go to DONE; done=1 for exactly one cycle, ocnt equal to n; then return to IDLE.
REQ-018 Latency: start sampled at edge E; sval high cycles E+1..E+7; done high cycle E+8; ready high again from E+9.
REQ-019 start while ready=0 SHALL be ignored; no queuing.
REQ-020 ww2..ww0 changes after the latching edge SHALL NOT affect the current word.
REQ-021 Boundary n=0: word=0000000, sout=0 all 7 cycles, ocnt=0 at done.
REQ-022 Boundary n=7: word=1111111, sout=1 all 7 cycles, ocnt=7 at done.
REQ-023 word SHALL hold its value through DONE and IDLE until the next accepted start.

Reset
REQ-024 rst=1 SHALL immediately force IDLE: ready=1, word=0, sout=0, sval=0, ocnt=0, done=0, independent of clk.
REQ-025 rst asserted mid-SHIFT or in DONE SHALL abort the request with no done pulse; the first start after release starts a fresh request.
REQ-026 start sampled at the first edge after rst deasserts SHALL be accepted.

Configuration
REQ-027 Macro OC_7_SERIAL_GEN_PARITY_EN: when defined, add output par (1 bit) = XOR of word, registered at load, reset 0, held until next load.
REQ-028 Without OC_7_SERIAL_GEN_PARITY_EN: port par absent; all other behaviour identical.

Verification
REQ-029 rst pulse, then n=3 and start at edge E -> word=0000111; sout 1,1,1,0,0,0,0 at E+1..E+7; done at E+8; ocnt=3.
REQ-030 n=0 and n=7 requests -> sout all 0 / all 1; ocnt 0 / 7 at done; word 0000000 / 1111111.
REQ-031 MSB_FIRST=1, n=2 -> sout 0,0,0,0,0,1,1.
REQ-032 start held high continuously and n changed mid-SHIFT -> only one request per IDLE, word unchanged, back-to-back requests 9 cycles apart.
REQ-033 rst asserted at E+4 of an n=5 request -> outputs zero asynchronously, no done; next n=1 request completes normally with ocnt=1.
REQ-034 With OC_7_SERIAL_GEN_PARITY_EN: n=5 -> par=1; n=6 -> par=0.
